shift_deser: RTL
================

// Module: shift_deser
// PURPOSE
// - Receive end of the 4-bit shift-register serial link: collects an LSB-first bit stream (q[0] of the
//   right-shifting transmitter, one bit per ena cycle) and reassembles it into parallel words.
// - Sits between the serial link and a word consumer; presents words over a valid/ready holding register.
// PARAMETERS
// - WIDTH  4  data bits per frame (>=2)
// - CNTW   $clog2(WIDTH+1)  width of bit_cnt
// PORTS
// - clk         in   1      rising-edge clock
// - areset_n    in   1      asynchronous, active-low reset
// - sync        in   1      frame start pulse; restarts bit collection
// - ena         in   1      serial bit valid this cycle
// - sin         in   1      serial data bit
// - out_ready   in   1      consumer accepts out_data when out_valid & out_ready
// - out_valid   out  1      holding register holds an unconsumed word
// - out_data    out  WIDTH  received word, bit 0 = first bit received
// - busy        out  1      frame in progress (state != IDLE)
// - bit_cnt     out  CNTW   bits collected in the current frame
// - overrun     out  1      sticky: a word completed while holding register full and not being read
// - parity_err  out  1      sticky parity error (tied 0 unless PARITY_CHECK_EN)
// BEHAVIOUR
// - Reset (areset_n=0, async): state=IDLE, shift reg=0, out_data=0, out_valid=0, bit_cnt=0, overrun=0,
//   parity_err=0, busy=0. Reset mid-frame discards the partial word.
// - States: IDLE -> SHIFT on sync. SHIFT -> IDLE (or PARITY with macro) after WIDTH-th sampled bit.
//   PARITY -> IDLE after parity bit sampled. ena in IDLE is ignored.
// - Sampling: in SHIFT, each ena cycle: sr <= {sin, sr[WIDTH-1:1]}; bit_cnt++. No ena -> hold.
// - sync && ena same cycle: frame restarts and that bit is bit 0 (bit_cnt=1 after edge).
// - sync in SHIFT/PARITY: partial word discarded, bit_cnt=0 (or 1 if ena), stays/returns to SHIFT.
// - Completion: on the edge sampling bit WIDTH-1 (no macro), out_data <= {sin, sr[WIDTH-1:1]},
//   out_valid <= 1, bit_cnt <= 0, state <= IDLE. Latency 0 cycles after last sampling edge.
// - Handshake: out_valid & out_ready at an edge -> out_valid <= 0 unless a new word completes on the
//   same edge, in which case new word loads and out_valid stays 1 (no overrun).
// - Overrun: word completes while out_valid=1 & out_ready=0 -> new word overwrites out_data,
//   overrun <= 1. overrun and parity_err clear only on sync or reset.
// - out_data stable while out_valid=1 except on overrun overwrite.
// CONFIGURATION
// - PARITY_CHECK_EN defined: after WIDTH data bits, state PARITY samples one even-parity bit on next ena;
//   word published on that edge; parity_err <= 1 if ^{sin, data} != 0 (word still published).
//   bit_cnt counts to WIDTH+1.
// - PARITY_CHECK_EN undefined: no PARITY state, word published on WIDTH-th bit, parity_err constant 0.
// TESTING (WIDTH=4)
// - Reset: areset_n=0 mid-frame between clock edges -> all outputs 0 immediately, before next clk edge.
// - sync, then ena with sin=1,1,0,1 on consecutive cycles, out_ready=1 -> out_data=4'hB, out_valid=1 one
//   cycle, busy 1->0, bit_cnt 0,1,2,3,0.
// - Gapped ena (bits 0,1,1,0 with idle cycles between) -> out_data=4'h6, bit_cnt holds during gaps.
// - Two frames 4'h3 then 4'hC, out_ready=0 -> out_data=4'hC, overrun=1; next sync clears overrun.
// - sync at bit_cnt=2 with ena=1 sin=1, then 0,0,1 -> out_data=4'h9 (partial word discarded).
// - PARITY_CHECK_EN: data 4'hB + parity 1 -> parity_err=0; data 4'hB + parity 0 -> parity_err=1,
//   out_data=4'hB.

Source files
------------

// File: rtl/shift_deser_if.sv
// ----------------------------------------------------------------------------
// shift_deser_if
// Word-side valid/ready bus of the serial deserializer.
//
// Signals:
//   out_valid  producer -> consumer  holding register holds an unconsumed word
//   out_ready  consumer -> producer  word is taken when out_valid & out_ready
//   out_data   producer -> consumer  received word, bit 0 = first bit received
//
// Modports:
//   master  the deserializer (drives out_valid/out_data)
//   slave   the word consumer (drives out_ready)
// ----------------------------------------------------------------------------
interface shift_deser_if #(
    parameter int WIDTH = 4
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/shift_deser.sv
// ----------------------------------------------------------------------------
// shift_deser
// Receive end of the shift-register serial link. Collects an LSB-first bit
// stream (one bit per ena cycle, framed by a sync pulse) and publishes each
// completed word through a valid/ready holding register.
//
// Parameters:
//   WIDTH  data bits per frame (>= 2)
//   CNTW   width of bit_cnt
//
// Ports:
//   clk         rising-edge clock
//   areset_n    asynchronous active-low reset
//   sync        frame start pulse; restarts bit collection
//   ena         serial bit valid this cycle
//   sin         serial data bit
//   out_if      word bus (master side): out_valid, out_ready, out_data
//   busy        frame in progress
//   bit_cnt     bits collected in the current frame
//   overrun     sticky: word completed while holding register full and unread
//   parity_err  sticky parity error
//
// Build option:
//   PARITY_CHECK_EN  when defined, each frame carries a trailing even-parity
//                    bit; the word is published when that bit is sampled and
//                    a bad parity sets parity_err. When undefined, the word is
//                    published on the last data bit and parity_err is 0.
// ----------------------------------------------------------------------------
module shift_deser #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic            sync,
    input  logic            ena,
    input  logic            sin,
    shift_deser_if.master   out_if,
    output logic            busy,
    output logic [CNTW-1:0] bit_cnt,
    output logic            overrun,
    output logic            parity_err
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word_nxt;
    logic [CNTW-1:0]  cnt_nxt;
    logic             complete;
`ifdef PARITY_CHECK_EN
    logic             perr_set;
`endif

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign sr_shift = {sin, sr[WIDTH-1:1]};
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, shift register and bit counter
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = bit_cnt;
        word_nxt  = sr_shift;
        complete  = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_set  = 1'b0;
`endif
        if (sync) begin
            // Restart from any state; a bit sampled together with sync is
            // bit 0 of the new frame.
            state_nxt = SHIFT;
            sr_nxt    = '0;
            cnt_nxt   = '0;
            if (ena) begin
                sr_nxt  = {sin, {(WIDTH - 1){1'b0}}};
                cnt_nxt = CNTW'(1);
            end
        end else if (ena) begin
            case (state)
                SHIFT: begin
                    sr_nxt = sr_shift;
                    if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = PARITY;
                        cnt_nxt   = bit_cnt + 1'b1;
`else
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        complete  = 1'b1;
`endif
                    end else begin
                        cnt_nxt = bit_cnt + 1'b1;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    // Data is already complete in sr; this edge only samples
                    // the parity bit.
                    word_nxt  = sr;
                    complete  = 1'b1;
                    perr_set  = sin ^ (^sr);
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sr               <= '0;
            bit_cnt          <= '0;
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            bit_cnt <= cnt_nxt;
            if (complete) begin
                // A word landing on an unread, unaccepted register overwrites it.
                out_if.out_data  <= word_nxt;
                out_if.out_valid <= 1'b1;
                if (out_if.out_valid && !out_if.out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_if.out_valid && out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end
            // sync and complete are mutually exclusive, so no ordering hazard.
            if (sync) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            parity_err <= 1'b0;
        end else if (sync) begin
            parity_err <= 1'b0;
        end else if (perr_set) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
